// File: rtl/ifetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
// State encodings, default widths and MIPS field positions.
package ifetch_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2
    } fetch_state_t;

    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 32;

    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 26;
    localparam int IMM_MSB  = 15;
    localparam int IMM_LSB  = 0;
    localparam int JTGT_MSB = 25;
    localparam int JTGT_LSB = 0;

endpackage

// File: rtl/ifetch_next_pc.sv
// Next fetch address select: sequential, branch or jump.
// Holds the PC at the last word instead of wrapping.
module ifetch_next_pc
    import ifetch_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] fetch_pc,
    input  logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_valid,
    input  logic              jump,
    input  logic              branch_taken,
    input  logic [15:0]       branch_offset,
    input  logic [25:0]       jump_target,
    output logic [ADDR_W-1:0] next_pc,
    output logic              redirect,
    output logic              at_end
);

    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] jmp_tgt;
    logic              sel_jmp;
    logic              sel_br;
    logic              sel_seq;

    logic unused_hi;
    assign unused_hi = ^{branch_offset[15:ADDR_W], jump_target[25:ADDR_W]};

    // Only a live instruction may redirect the stream.
    assign redirect = instr_valid & (jump | branch_taken);
    assign at_end   = &fetch_pc;

    assign br_tgt  = instr_pc + ADDR_W'(1) + branch_offset[ADDR_W-1:0];
    assign jmp_tgt = jump_target[ADDR_W-1:0];

    assign sel_jmp = redirect & jump;
    assign sel_br  = redirect & ~jump;
    assign sel_seq = ~redirect & ~at_end;

    always_comb begin
        next_pc = fetch_pc;
        unique case (1'b1)
            sel_jmp: next_pc = jmp_tgt;
            sel_br:  next_pc = br_tgt;
            sel_seq: next_pc = fetch_pc + ADDR_W'(1);
            default: next_pc = fetch_pc;
        endcase
    end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: owns the PC, registers fetched words
// for decode, handles stall, one-bubble redirects and end-of-memory halt.
module ifetch_ctrl
    import ifetch_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [15:0]       branch_offset,
    input  logic              jump,
    input  logic [25:0]       jump_target,
    output logic [ADDR_W-1:0] imem_adrx,
    input  logic [DATA_W-1:0] imem_data,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    output logic              halted
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;
    logic              valid_q, valid_d;

    logic [ADDR_W-1:0] next_pc;
    logic              redirect;
    logic              at_end;

    ifetch_next_pc #(
        .ADDR_W(ADDR_W)
    ) u_next_pc (
        .fetch_pc     (fetch_pc_q),
        .instr_pc     (ipc_q),
        .instr_valid  (valid_q),
        .jump         (jump),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset),
        .jump_target  (jump_target),
        .next_pc      (next_pc),
        .redirect     (redirect),
        .at_end       (at_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= '0;
            instr_q    <= '0;
            ipc_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            instr_q    <= instr_d;
            ipc_q      <= ipc_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        instr_d    = instr_q;
        ipc_d      = ipc_q;
        valid_d    = valid_q;
        unique case (state_q)
            S_IDLE, S_HALT: begin
                valid_d = 1'b0;
                if (start) begin
                    state_d    = S_FETCH;
                    fetch_pc_d = '0;
                end
            end
            S_FETCH: begin
                if (!stall) begin
                    fetch_pc_d = next_pc;
                    if (redirect) begin
                        // Word fetched this cycle is on the wrong path.
                        valid_d = 1'b0;
                    end else begin
                        instr_d = imem_data;
                        ipc_d   = fetch_pc_q;
                        valid_d = 1'b1;
                        if (at_end)
                            state_d = S_HALT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign imem_adrx   = fetch_pc_q;
    assign instr       = instr_q;
    assign instr_pc    = ipc_q;
    assign instr_valid = valid_q;
    assign halted      = (state_q == S_HALT);

endmodule
